motor_step_gen: RTL and testbench

- Per-axis step/direction pulse generator, one instance per motor, directly downstream of the UART command parser in top.
- Accepts a one-cycle load of {divider, step count, direction}, then emits exactly that many step pulses at the programmed period.
- Raises active while moving and pulses done on completion; the parser uses the falling edge of active to clear its pending flag.

---
 rtl/motor_pkg.sv | 17 +
 rtl/motor_step_gen_sync.sv | 27 ++
 rtl/motor_step_gen.sv | 166 ++++++++++++++++
 tb/tb_motor_step_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared constants and state encoding for the step/direction generator.
// CLK_HZ is also consumed by the UART blocks.
package motor_pkg;

  localparam int unsigned CLK_HZ        = 25000000;
  localparam int unsigned PULSE_W_DEF   = 50;
  localparam int unsigned DIR_SETUP_DEF = 25;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIR_SETUP = 2'd1,
    ST_STEP_HIGH = 2'd2,
    ST_STEP_LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/motor_step_gen_sync.sv
// Two-flop synchroniser with configurable reset value, used for the
// active-low endstop input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/motor_step_gen.sv
// Per-axis step/direction pulse generator: load {divider, count, dir}, emit
// that many step pulses at period max(divider, 2*PULSE_W). Endstop halting is
// built only when ENDSTOP_HALT_EN is defined.
module motor_step_gen
  import motor_pkg::*;
#(
  parameter int unsigned PULSE_W   = PULSE_W_DEF,
  parameter int unsigned DIR_SETUP = DIR_SETUP_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] divider,
  input  logic [CNT_W-1:0] stepsToGo,
  input  logic             dirInput,
  input  logic             abort,
  input  logic             term,
  output logic             step,
  output logic             dir,
  output logic             active,
  output logic             done,
  output logic [CNT_W-1:0] stepsLeft
);

  localparam int unsigned TW = CNT_W + 1;

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_steps_left;
  logic             r_step;
  logic             r_dir;
  logic             r_active;
  logic             r_done;
  logic             r_halt;

  logic [TW-1:0]    w_period;
  logic [TW-1:0]    w_low_time;
  logic             w_endstop;

`ifdef ENDSTOP_HALT_EN
  logic w_term_sync;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_term_sync (
    .i_clk(CLK),
    .i_rst(reset),
    .i_d  (term),
    .o_q  (w_term_sync)
  );

  assign w_endstop = ~w_term_sync;
`else
  logic w_unused_term;
  assign w_unused_term = term;
  assign w_endstop     = 1'b0;
`endif

  // One extra bit keeps 2*PULSE_W and the clamped period from wrapping.
  always_comb begin
    w_period = {1'b0, r_div};
    if (w_period < TW'(2 * PULSE_W)) begin
      w_period = TW'(2 * PULSE_W);
    end
    w_low_time = w_period - TW'(PULSE_W) - TW'(1);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_div        <= '0;
      r_steps_left <= '0;
      r_step       <= 1'b0;
      r_dir        <= 1'b0;
      r_active     <= 1'b0;
      r_done       <= 1'b0;
      r_halt       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE && abort) begin
        r_state  <= ST_IDLE;
        r_step   <= 1'b0;
        r_active <= 1'b0;
        r_done   <= 1'b1;
        r_halt   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (load && !abort) begin
              if (stepsToGo == '0) begin
                r_done <= ~r_done;
              end else begin
                r_dir        <= dirInput;
                r_steps_left <= stepsToGo;
                r_div        <= divider;
                r_active     <= 1'b1;
                r_timer      <= TW'(DIR_SETUP - 1);
                r_state      <= ST_DIR_SETUP;
              end
            end
          end
          ST_DIR_SETUP: begin
            if (w_endstop) begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end else if (r_timer == '0) begin
              r_step  <= 1'b1;
              r_timer <= TW'(PULSE_W - 1);
              r_state <= ST_STEP_HIGH;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          ST_STEP_HIGH: begin
            // An endstop during the high phase is remembered so the pulse completes.
            if (w_endstop) begin
              r_halt <= 1'b1;
            end
            if (r_timer == '0) begin
              r_step       <= 1'b0;
              r_steps_left <= (r_steps_left != '0) ? r_steps_left - CNT_W'(1) : '0;
              if (r_halt || w_endstop) begin
                r_state  <= ST_IDLE;
                r_active <= 1'b0;
                r_done   <= 1'b1;
                r_halt   <= 1'b0;
              end else begin
                r_timer <= w_low_time;
                r_state <= ST_STEP_LOW;
              end
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          ST_STEP_LOW: begin
            if (w_endstop || (r_timer == '0 && r_steps_left == '0)) begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end else if (r_timer == '0) begin
              r_step  <= 1'b1;
              r_timer <= TW'(PULSE_W - 1);
              r_state <= ST_STEP_HIGH;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign step      = r_step;
  assign dir       = r_dir;
  assign active    = r_active;
  assign done      = r_done;
  assign stepsLeft = r_steps_left;

endmodule

// File: tb/tb_motor_step_gen.sv
// Self-checking bench for motor_step_gen: directed vector table, hand-written
// corner sequences and randomized commands against a cycle-timeline model.
module tb_motor_step_gen;

  localparam int PW    = 50;
  localparam int DS    = 25;
  localparam int S     = DS + 1;
  localparam int P_MIN = 2 * PW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] divider = '0;
  logic [15:0] stepsToGo = '0;
  logic        dirInput = 1'b0;
  logic        abort = 1'b0;
  logic        term = 1'b1;
  logic        step;
  logic        dir;
  logic        active;
  logic        done;
  logic [15:0] stepsLeft;

  int checks = 0;
  int errors = 0;
  int prev_sl = 0;
  bit prev_dir = 1'b0;

  motor_step_gen #(
    .PULSE_W  (PW),
    .DIR_SETUP(DS),
    .CNT_W    (16)
  ) dut (
    .CLK      (clk),
    .reset    (reset),
    .load     (load),
    .divider  (divider),
    .stepsToGo(stepsToGo),
    .dirInput (dirInput),
    .abort    (abort),
    .term     (term),
    .step     (step),
    .dir      (dir),
    .active   (active),
    .done     (done),
    .stepsLeft(stepsLeft)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int div;
    int n;
    bit d;
    int abort_at;
    int busy_at;
    int halt_k;
    int exp_edges;
    int exp_done;
  } vec_t;

`ifdef ENDSTOP_HALT_EN
  localparam int ES_EDGES = 2;
  localparam int ES_DONE  = 276;
`else
  localparam int ES_EDGES = 10;
  localparam int ES_DONE  = 2026;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Remaining steps at cycle t: each pulse k finishes at S + k*P + PW.
  function automatic int sl_at(input int t, input int n, input int p);
    int cnt;
    if (t < S + PW) cnt = 0;
    else cnt = (t - S - PW) / p + 1;
    if (cnt > n) cnt = n;
    return n - cnt;
  endfunction

  task automatic run_cmd(input int div, input int n, input bit d, input int abort_at,
                         input int busy_at, input int halt_k, input int exp_edges,
                         input int exp_done, input string tag);
    int p, end_t, stop, stop_sl, term_t, edges, done_t;
    bit halted;
    bit e_step, e_act, e_done, e_dir;
    int e_sl;
    logic prev_step;
    p      = (div > P_MIN) ? div : P_MIN;
    end_t  = (n == 0) ? 1 : S + n * p;
    stop   = end_t;
    halted = 1'b0;
    if (n > 0 && abort_at >= 1 && abort_at < end_t) stop = abort_at + 1;
`ifdef ENDSTOP_HALT_EN
    if (n > 0 && halt_k >= 0 && halt_k < n && (S + halt_k * p + PW) < stop) begin
      stop   = S + halt_k * p + PW;
      halted = 1'b1;
    end
`endif
    if (n == 0) stop_sl = prev_sl;
    else if (halted) stop_sl = sl_at(stop, n, p);
    else stop_sl = sl_at(stop - 1, n, p);
    term_t = (halt_k >= 0) ? S + halt_k * p + 19 : -1;

    load      = 1'b1;
    divider   = 16'(div);
    stepsToGo = 16'(n);
    dirInput  = d;
    abort     = 1'b0;
    next_cycle();
    load      = 1'b0;
    edges     = 0;
    done_t    = -1;
    prev_step = 1'b0;
    for (int t = 1; t <= stop + 3; t++) begin
      abort = (t == abort_at);
      load  = (t == busy_at);
      if (t == busy_at) begin
        divider   = 16'd50;
        stepsToGo = 16'd9;
        dirInput  = ~d;
      end
      term = (term_t >= 0 && t >= term_t) ? 1'b0 : 1'b1;
      if (t < stop) begin
        e_act  = 1'b1;
        e_dir  = d;
        e_done = 1'b0;
        e_step = (t >= S) && ((t - S) / p < n) && ((t - S) % p < PW);
        e_sl   = sl_at(t, n, p);
      end else begin
        e_act  = 1'b0;
        e_dir  = (n > 0) ? d : prev_dir;
        e_done = (t == stop);
        e_step = 1'b0;
        e_sl   = stop_sl;
      end
      check($sformatf("%s t=%0d {step,active,done,dir,stepsLeft}", tag, t),
            {12'd0, step, active, done, dir, stepsLeft},
            {12'd0, e_step, e_act, e_done, e_dir, 16'(e_sl)});
      if (step === 1'b1 && prev_step === 1'b0) edges++;
      if (done === 1'b1 && done_t < 0) done_t = t;
      prev_step = step;
      next_cycle();
    end
    abort = 1'b0;
    load  = 1'b0;
    term  = 1'b1;
    prev_sl = stop_sl;
    if (n > 0) prev_dir = d;
    if (exp_edges >= 0) begin
      check($sformatf("%s rising edges", tag), 32'(edges), 32'(exp_edges));
      check($sformatf("%s done cycle", tag), 32'(done_t), 32'(exp_done));
    end
    repeat (3) next_cycle();
  endtask

  initial begin
    vec_t tbl[9];
    int   n, div, end_t, ab, bz, bz_hi;
    bit   d;

    tbl[0] = '{200, 3, 1'b1, -1, -1, -1, 3, 626};
    tbl[1] = '{200, 3, 1'b1, -1, 100, -1, 3, 626};
    tbl[2] = '{200, 3, 1'b1, 236, -1, -1, 2, 237};
    tbl[3] = '{10, 2, 1'b0, -1, -1, -1, 2, 226};
    tbl[4] = '{77, 0, 1'b1, -1, -1, -1, 0, 1};
    tbl[5] = '{0, 1, 1'b1, -1, -1, -1, 1, 126};
    tbl[6] = '{1, 2, 1'b0, -1, -1, -1, 2, 226};
    tbl[7] = '{301, 2, 1'b1, -1, -1, -1, 2, 628};
    tbl[8] = '{200, 10, 1'b1, -1, -1, 1, ES_EDGES, ES_DONE};

    repeat (3) next_cycle();
    check("reset outputs", {12'd0, step, active, done, dir, stepsLeft}, 32'd0);
    reset = 1'b0;
    repeat (2) next_cycle();
    check("idle after reset", {12'd0, step, active, done, dir, stepsLeft}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].div, tbl[i].n, tbl[i].d, tbl[i].abort_at, tbl[i].busy_at,
              tbl[i].halt_k, tbl[i].exp_edges, tbl[i].exp_done, $sformatf("vec%0d", i));
    end

    // abort together with load in IDLE: load dropped, no done
    load = 1'b1; abort = 1'b1; stepsToGo = 16'd5; divider = 16'd200; dirInput = ~prev_dir;
    next_cycle();
    load = 1'b0; abort = 1'b0;
    check("abort+load active", {31'd0, active}, 32'd0);
    check("abort+load done", {31'd0, done}, 32'd0);
    check("abort+load dir", {31'd0, dir}, {31'd0, prev_dir});
    next_cycle();
    check("abort+load later active", {31'd0, active}, 32'd0);

    // abort alone in IDLE
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    check("idle abort done", {31'd0, done}, 32'd0);

    // zero-step load on consecutive cycles must not give back-to-back done
    load = 1'b1; stepsToGo = 16'd0;
    next_cycle();
    check("zero load #1 done", {31'd0, done}, 32'd1);
    next_cycle();
    load = 1'b0;
    check("zero load #2 done", {31'd0, done}, 32'd0);
    repeat (2) next_cycle();

    // reset mid-run clears outputs without waiting for a clock edge
    load = 1'b1; divider = 16'd200; stepsToGo = 16'd3; dirInput = 1'b1;
    next_cycle();
    load = 1'b0;
    repeat (40) next_cycle();
    check("mid-run step high", {30'd0, step, active}, 32'd3);
    reset = 1'b1;
    #1;
    check("async reset outputs", {12'd0, step, active, done, dir, stepsLeft}, 32'd0);
    next_cycle();
    reset = 1'b0;
    prev_sl = 0;
    prev_dir = 1'b0;
    repeat (2) next_cycle();

    for (int i = 0; i < 12; i++) begin
      n     = $urandom_range(0, 4);
      div   = $urandom_range(0, 300);
      d     = 1'($urandom_range(0, 1));
      end_t = (n == 0) ? 1 : S + n * ((div > P_MIN) ? div : P_MIN);
      ab    = -1;
      bz    = -1;
      if (n > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, end_t + 2);
      bz_hi = (ab >= 1 && ab < end_t) ? ab : end_t - 1;
      if (n > 0 && $urandom_range(0, 1) == 0) bz = $urandom_range(1, bz_hi);
      run_cmd(div, n, d, ab, bz, -1, -1, -1, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
